// File: rtl/ds_dac_sample_ctrl.sv
// Sample-rate controller feeding the delta-sigma DAC: buffers PCM samples in a FIFO,
// primes to half full, then releases one sample per programmable sample period.
module ds_dac_sample_ctrl #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [DIV_W-1:0]           div,
    input  logic [W-1:0]               s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [W-1:0]               pcm_out,
    output logic                       sample_tick,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                underflow_cnt,
    input  logic                       clr_underflow,
    output logic                       running
);

    // state | meaning
    // IDLE  | disabled; FIFO empty, output mid-scale, no pushes accepted
    // PRIME | accepting pushes until the FIFO is half full
    // RUN   | divider counting; each tick pops a sample or records an underflow
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       pcm_q, pcm_d;
    logic               tick_q, tick_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [15:0]        uf_cnt_q, uf_cnt_d;
    logic [W-1:0]       mem_q [DEPTH];
    logic [W-1:0]       mem_d [DEPTH];

    logic ready_int;
    logic flush;
    logic push;
    logic pop;
    logic underflow;

    assign ready_int = (level_q != FULL_LVL) && (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pcm_d     = pcm_q;
        tick_d    = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        uf_cnt_d  = uf_cnt_q;
        mem_d     = mem_q;

        flush     = !en || (state_q == ST_IDLE);
        push      = s_valid && ready_int;
        pop       = !flush && (state_q == ST_RUN) && tick_q && (level_q != '0);
        underflow = !flush && (state_q == ST_RUN) && tick_q && (level_q == '0);

        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            pcm_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Leaving for IDLE (or sitting in it) discards the buffer and forces mid-scale.
        if (flush) begin
            state_d  = en ? ST_PRIME : ST_IDLE;
            cnt_d    = '0;
            pcm_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    cnt_d = '0;
                    if (level_q >= HALF_LVL) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (cnt_q >= div) begin
                        tick_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (clr_underflow) begin
            uf_cnt_d = '0;
        end else if (underflow && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pcm_q    <= '0;
            tick_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            uf_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pcm_q    <= pcm_d;
            tick_q   <= tick_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign s_ready       = ready_int;
    assign pcm_out       = pcm_q;
    assign sample_tick   = tick_q;
    assign fifo_level    = level_q;
    assign underflow_cnt = uf_cnt_q;
    assign running       = (state_q == ST_RUN);

endmodule

// File: tb/tb_ds_dac_sample_ctrl.sv
// Bench for ds_dac_sample_ctrl: directed stimulus, accepted samples queued in a
// scoreboard and checked by a monitor one cycle after each sample_tick.
module tb_ds_dac_sample_ctrl;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] div;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] pcm_out;
    logic        sample_tick;
    logic [3:0]  fifo_level;
    logic [15:0] underflow_cnt;
    logic        clr_underflow;
    logic        running;

    ds_dac_sample_ctrl #(.W(16), .DEPTH(8), .DIV_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .div           (div),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .pcm_out       (pcm_out),
        .sample_tick   (sample_tick),
        .fifo_level    (fifo_level),
        .underflow_cnt (underflow_cnt),
        .clr_underflow (clr_underflow),
        .running       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    logic [15:0] last_pcm = '0;
    logic [15:0] exp_uf   = '0;
    logic [15:0] pend_pcm = '0;
    logic [15:0] pend_uf  = '0;
    bit          pend     = 1'b0;
    bit          mon_quiet   = 1'b0;
    bit          chk_spacing = 1'b0;
    int          spacing_exp = 1;
    int          cyc = 0;
    int          last_tick_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle; a push the DUT accepts in this cycle enters the scoreboard.
    task automatic step();
        logic        acc;
        logic [15:0] d;
        acc = s_valid && s_ready && en && !reset;
        d   = s_data;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(d);
    endtask

    always @(negedge clk) begin
        logic [15:0] uf_next;
        cyc++;
        if (pend) begin
            if (!mon_quiet) begin
                chk("pcm_after_tick", {16'd0, pcm_out}, {16'd0, pend_pcm});
                chk("uf_after_tick", {16'd0, underflow_cnt}, {16'd0, pend_uf});
            end
            pend = 1'b0;
        end
        if (reset) begin
            exp_q.delete();
            last_pcm      = '0;
            exp_uf        = '0;
            last_tick_cyc = -1;
        end else begin
            uf_next = exp_uf;
            if (!en) begin
                exp_q.delete();
                last_pcm      = '0;
                last_tick_cyc = -1;
            end else if (sample_tick) begin
                if (exp_q.size() > 0) last_pcm = exp_q.pop_front();
                else if (uf_next != 16'hFFFF) uf_next = uf_next + 16'd1;
                pend     = 1'b1;
                pend_pcm = last_pcm;
                if (chk_spacing && !mon_quiet && last_tick_cyc >= 0)
                    chk("tick_spacing", cyc - last_tick_cyc, spacing_exp);
                last_tick_cyc = cyc;
            end
            if (clr_underflow) uf_next = '0;
            exp_uf  = uf_next;
            pend_uf = exp_uf;
        end
    end

    initial begin
        int n;
        reset = 1'b1; en = 1'b0; div = '0; s_data = '0; s_valid = 1'b0; clr_underflow = 1'b0;
        @(posedge clk); #1;
        repeat (3) step();
        chk("rst_pcm", pcm_out, 0);
        chk("rst_tick", sample_tick, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_running", running, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_uf", underflow_cnt, 0);
        reset = 1'b0;
        step();

        // Basic run, div=3, followed by underflow
        div = 16'd3; en = 1'b1;
        step();
        chk("prime_ready", s_ready, 1);
        chk("prime_not_running", running, 0);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h1000 * (i + 1));
            step();
        end
        s_valid = 1'b0;
        chk("primed_level", fifo_level, 4);
        chk("primed_not_running", running, 0);
        spacing_exp = 4; chk_spacing = 1'b1;
        step();
        chk("run_entered", running, 1);
        repeat (3) step();
        chk("no_early_tick", sample_tick, 0);
        step();
        chk("first_tick", sample_tick, 1);
        step();
        chk("first_pcm", pcm_out, 16'h1000);
        chk("level_after_pop", fifo_level, 3);
        repeat (25) step();
        chk("uf_count_3", underflow_cnt, 3);
        chk("uf_hold_pcm", pcm_out, 16'h4000);
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        chk("uf_cleared", underflow_cnt, 0);

        // Disable mid-run with level 5 and pcm 0x7FFF
        s_valid = 1'b1; s_data = 16'h7FFF;
        step();
        s_valid = 1'b0;
        repeat (8) step();
        chk_spacing = 1'b0;
        div = 16'd100;
        step();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 16'(16'h0101 * (i + 1));
            step();
        end
        s_valid = 1'b0;
        chk("pre_dis_level", fifo_level, 5);
        chk("pre_dis_pcm", pcm_out, 16'h7FFF);
        en = 1'b0;
        step();
        chk("dis_running", running, 0);
        chk("dis_pcm", pcm_out, 0);
        chk("dis_level", fifo_level, 0);
        chk("dis_ready", s_ready, 0);
        chk("dis_uf_kept", underflow_cnt, 2);
        step();

        // Full FIFO back-pressure, div=100
        en = 1'b1; div = 16'd100; s_valid = 1'b1; s_data = 16'h0A00;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            s_data = s_data + 16'd1;
        end
        chk("full_level", fifo_level, 8);
        chk("full_ready", s_ready, 0);
        chk("full_running", running, 1);
        n = 0;
        while (!sample_tick && n < 200) begin
            step();
            s_data = s_data + 16'd1;
            n++;
        end
        chk("full_tick_delay", n, 96);
        chk("tick_full_ready", s_ready, 0);
        chk("tick_full_level", fifo_level, 8);
        step();
        s_data = s_data + 16'd1;
        chk("freed_ready", s_ready, 1);
        chk("freed_level", fifo_level, 7);
        step();
        chk("refill_level", fifo_level, 8);
        chk("refill_ready", s_ready, 0);
        en = 1'b0; s_valid = 1'b0;
        repeat (2) step();

        // div=0 with simultaneous push and pop
        div = 16'd0; en = 1'b1;
        step();
        s_data = 16'h0C00;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            step();
            s_data = s_data + 16'd1;
        end
        s_valid = 1'b0;
        repeat (2) step();
        spacing_exp = 1; chk_spacing = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("div0_tick", sample_tick, 1);
            chk("div0_level", fifo_level, 4);
            step();
            s_data = s_data + 16'd1;
        end
        s_valid = 1'b0;
        repeat (10) step();

        // Saturation, then reset mid-run
        mon_quiet = 1'b1;
        repeat (65540) step();
        chk("uf_saturated", underflow_cnt, 16'hFFFF);
        chk("sat_running", running, 1);
        s_valid = 1'b1; s_data = 16'h1234; reset = 1'b1;
        step();
        chk("mid_rst_pcm", pcm_out, 0);
        chk("mid_rst_tick", sample_tick, 0);
        chk("mid_rst_ready", s_ready, 0);
        chk("mid_rst_running", running, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_uf", underflow_cnt, 0);
        reset = 1'b0; en = 1'b0; s_valid = 1'b0;
        step();
        mon_quiet = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ds_dac_sample_ctrl.md
# ds_dac_sample_ctrl

Sample-rate controller that sits in front of the 1-bit delta-sigma DAC in the DDS core. It buffers signed PCM samples from the producer (DDS or CPU MMIO path) in a small FIFO. It releases one sample to the DAC's `pcm_in` at a programmable sample rate, derived by dividing the system clock. It primes the buffer before starting, holds the last sample and counts events on underflow, and forces a mid-scale (zero) output when disabled.

## Interface

Parameters:

- `W`, default 16: PCM sample width (signed two's complement).
- `DEPTH`, default 8: FIFO depth, power of 2, at least 4.
- `DIV_W`, default 16: width of the sample-period divider.

Ports:

- `clk` (in, 1): system clock; the only clock.
- `reset` (in, 1): synchronous, active-high reset.
- `en` (in, 1): run enable.
- `div` (in, DIV_W): sample period minus 1, in `clk` cycles.
- `s_data` (in, W): input sample.
- `s_valid` (in, 1): input sample valid.
- `s_ready` (out, 1): FIFO can accept a sample.
- `pcm_out` (out, W): sample driven to the DAC `pcm_in`.
- `sample_tick` (out, 1): one-cycle pulse at each sample boundary.
- `fifo_level` (out, $clog2(DEPTH)+1): current FIFO occupancy.
- `underflow_cnt` (out, 16): saturating count of underflow events.
- `clr_underflow` (in, 1): clears `underflow_cnt`.
- `running` (out, 1): high while in RUN.

## Operation

Input handshake:

- A push occurs when `s_valid && s_ready`.
- `s_ready = (fifo_level != DEPTH) && state != IDLE`.
- A full FIFO refuses a push even if a pop occurs in the same cycle.

State machine, one-hot or binary (implementer's choice):

- **IDLE**:
  - `pcm_out = 0`, divider counter `cnt = 0`, FIFO held empty, `s_ready = 0`.
  - Goes to PRIME when `en = 1`.
- **PRIME**:
  - Accepts pushes. `cnt` is held at 0 and `pcm_out` stays 0.
  - Goes to RUN when `fifo_level >= DEPTH/2` at a clock edge.
  - Goes to IDLE if `en = 0`.
- **RUN**:
  - `cnt` increments every cycle.
  - When `cnt >= div`: assert `sample_tick` and set `cnt` to 0. The `>=` compare means a mid-run decrease of `div` takes effect without wrap.
  - On a tick with FIFO non-empty: pop the head into `pcm_out`.
  - On a tick with FIFO empty: `pcm_out` holds its previous value, `underflow_cnt` increments, and the state stays RUN. There is no re-prime.
  - Goes to IDLE if `en = 0`.
- **Exit to IDLE** from any state takes one cycle. In that cycle the FIFO is flushed (pointers reset), `cnt = 0` and `pcm_out = 0`.

Rules:

- `div = 0`: tick every cycle while in RUN.
- A push and a tick-pop in the same cycle on a non-empty, non-full FIFO leave `fifo_level` unchanged.
- A push into an empty FIFO in the same cycle as a tick counts as an underflow. There is no bypass; the pushed sample is popped at the next tick.
- `underflow_cnt` saturates at 0xFFFF.
- `clr_underflow` has priority. If it coincides with an underflow, the result is 0.
- `underflow_cnt` is not cleared by `en`. Only `reset` and `clr_underflow` clear it.
- `pcm_out` is passed to the DAC unmodified. The DAC applies its own bias, so a value of 0 is mid-scale.

## Timing

Reset values:

- `pcm_out = 0`, `sample_tick = 0`, `s_ready = 0`, `running = 0`.
- `fifo_level = 0`, `underflow_cnt = 0`.
- State is IDLE.

Latency and cadence:

- `sample_tick`, `s_ready`, `running` and `fifo_level` are registered or derived only from registers. There are no combinational paths from inputs to outputs.
- A tick is asserted in cycle N. The popped sample appears on `pcm_out` in cycle N+1 and `fifo_level` updates in cycle N+1.
- The first tick occurs `div+1` cycles after entering RUN.
- Tick spacing is `div+1` cycles while `div` is constant.
- A push accepted in cycle N is visible in `fifo_level` at N+1.
- `en` rises at cycle N: state is PRIME at N+1 and `s_ready` can be high at N+1.
- A synchronous `reset` mid-RUN returns all outputs to their reset values at the next edge, regardless of any in-flight push or tick.

## Test plan

- **Basic run:** reset, `en=1`, `div=3`, push 0x1000, 0x2000, 0x3000, 0x4000 back-to-back -> RUN entered after the 4th push. Ticks every 4 cycles. `pcm_out` steps 0x1000, 0x2000, 0x3000, 0x4000, each one cycle after its tick.
- **Underflow:** continue the basic run without pushes -> after 0x4000, each further tick holds `pcm_out=0x4000` and increments `underflow_cnt` (1, 2, 3, ...). `clr_underflow` returns it to 0.
- **Full FIFO back-pressure:** hold `s_valid=1` during PRIME/RUN with `div=100` -> `fifo_level` reaches 8 and `s_ready=0`. A tick-pop frees a slot, and `s_ready` rises the next cycle.
- **Disable mid-run:** `en` drops with `fifo_level=5` and `pcm_out=0x7FFF` -> the next cycle shows IDLE, `pcm_out=0`, `fifo_level=0`, `running=0`, and `underflow_cnt` unchanged.
- **`div=0` with simultaneous push and pop:** FIFO half full, push every cycle -> a tick every cycle, `fifo_level` constant at 4, and samples emerge in order.
- **Saturation and reset:** force 0x10000 underflows -> `underflow_cnt` stays at 0xFFFF. Asserting `reset` mid-RUN zeroes all outputs on the next edge.
